// File: rtl/collector_arbiter.sv
// collector_arbiter: round-robin front end that lets several router local
// ports share one packet collector. One packet at a time is captured into a
// holding register and replayed to the collector with a request/grant
// handshake. Delivered and timed-out packets are counted.
module collector_arbiter #(
    parameter int NPORTS    = 4,
    parameter int dataWidth = 32,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NPORTS*dataWidth-1:0] PacketIn,
    input  logic [NPORTS-1:0]           ReqUpStr,
    output logic [NPORTS-1:0]           GntUpStr,
    output logic [NPORTS-1:0]           UpStrFull,
    output logic [dataWidth-1:0]        PacketOut,
    output logic                        ReqDnStr,
    input  logic                        GntDnStr,
    input  logic                        DnStrFull,
    output logic [CNT_W-1:0]            PktCount,
    output logic [CNT_W-1:0]            DropCount,
    output logic [2:0]                  LastSender
);

    // Port vectors are padded to 8 entries so a 3-bit index always fits.
    localparam int         MAXP       = 8;
    localparam logic [0:0] IDLE       = 1'b0;
    localparam logic [0:0] BUSY       = 1'b1;
    localparam logic [3:0] NPORTS_W   = 4'(NPORTS);
    localparam logic [2:0] LAST_IDX   = 3'(NPORTS - 1);
    // The timer counts from 0; expiry happens on the edge it would reach TIMEOUT.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    logic [0:0]           state;
    logic [2:0]           pointer;
    logic [2:0]           curPort;
    logic [7:0]           timer;
    logic                 fullReg;
    logic [NPORTS-1:0]    gntReg;

    logic [dataWidth-1:0] portPkt [MAXP];
    logic [MAXP-1:0]      reqPad;
    logic [MAXP-1:0]      curMask;
    logic [MAXP-1:0]      eligible;
    logic                 anyReq;
    logic                 doGrant;
    logic [2:0]           winIdx;
    logic [3:0]           slot;

    genvar gi;
    generate
        for (gi = 0; gi < MAXP; gi++) begin : g_port
            if (gi < NPORTS) begin : g_real
                assign portPkt[gi] = PacketIn[gi*dataWidth +: dataWidth];
                assign reqPad[gi]  = ReqUpStr[gi];
            end else begin : g_pad
                assign portPkt[gi] = '0;
                assign reqPad[gi]  = 1'b0;
            end
            assign curMask[gi] = (curPort == 3'(gi));
        end
    endgenerate

    // While busy, the port owning the held packet may not win the recycle slot.
    assign eligible = (state == BUSY) ? (reqPad & ~curMask) : reqPad;

    // Pick the first eligible port at or after the pointer, wrapping modulo NPORTS.
    always_comb begin
        anyReq = 1'b0;
        winIdx = '0;
        slot   = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            slot = {1'b0, pointer} + 4'(i);
            if (slot >= NPORTS_W) begin
                slot = slot - NPORTS_W;
            end
            if (eligible[slot[2:0]]) begin
                anyReq = 1'b1;
                winIdx = slot[2:0];
            end
        end
    end

    // A new packet is accepted from IDLE, or in the same cycle the collector
    // takes the current one (back-to-back).
    assign doGrant = anyReq && ((state == IDLE) || GntDnStr);

    // Main control: acceptance, collector handshake, timeout and statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pointer    <= '0;
            curPort    <= '0;
            timer      <= '0;
            fullReg    <= 1'b0;
            gntReg     <= '0;
            ReqDnStr   <= 1'b0;
            PacketOut  <= '0;
            PktCount   <= '0;
            DropCount  <= '0;
            LastSender <= '0;
        end else begin
            gntReg <= '0;

            if (doGrant) begin
                PacketOut  <= portPkt[winIdx];
                gntReg     <= NPORTS'(1) << winIdx;
                LastSender <= winIdx;
                curPort    <= winIdx;
                pointer    <= (winIdx == LAST_IDX) ? 3'd0 : winIdx + 3'd1;
                timer      <= '0;
                fullReg    <= 1'b1;
                state      <= BUSY;
            end

            if (state == IDLE) begin
                if (anyReq) begin
                    ReqDnStr <= ~DnStrFull;
                end
            end else if (GntDnStr) begin
                // A grant beats a simultaneous timeout: the packet was delivered.
                PktCount <= PktCount + CNT_W'(1);
                if (anyReq) begin
                    ReqDnStr <= 1'b1;
                end else begin
                    ReqDnStr <= 1'b0;
                    fullReg  <= 1'b0;
                    state    <= IDLE;
                end
            end else if (timer == TIMER_LAST) begin
                DropCount <= DropCount + CNT_W'(1);
                ReqDnStr  <= 1'b0;
                fullReg   <= 1'b0;
                state     <= IDLE;
            end else begin
                timer    <= timer + 8'd1;
                ReqDnStr <= ~DnStrFull;
            end
        end
    end

    assign GntUpStr  = gntReg;
    assign UpStrFull = {NPORTS{fullReg}};

endmodule

// File: tb/tb_collector_arbiter.sv
// Bench for collector_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the arbiter rules.
module tb_collector_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 5;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*DW-1:0] PacketIn;
    logic [N-1:0]    ReqUpStr;
    logic [N-1:0]    GntUpStr;
    logic [N-1:0]    UpStrFull;
    logic [DW-1:0]   PacketOut;
    logic            ReqDnStr;
    logic            GntDnStr;
    logic            DnStrFull;
    logic [CW-1:0]   PktCount;
    logic [CW-1:0]   DropCount;
    logic [2:0]      LastSender;

    collector_arbiter #(
        .NPORTS(N), .dataWidth(DW), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .PacketIn(PacketIn), .ReqUpStr(ReqUpStr),
        .GntUpStr(GntUpStr), .UpStrFull(UpStrFull), .PacketOut(PacketOut),
        .ReqDnStr(ReqDnStr), .GntDnStr(GntDnStr), .DnStrFull(DnStrFull),
        .PktCount(PktCount), .DropCount(DropCount), .LastSender(LastSender)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    string phase = "reset";

    // Reference model state
    bit            mBusy;
    int            mPtr, mCur, mTimer;
    logic [DW-1:0] eOut;
    logic [N-1:0]  eGnt;
    bit            eReqDn, eFull;
    int            ePkt, eDrop, eLast;

    // Environment controls
    bit collOn;
    int pmode [N];   // 0: no new requests, 1: re-request at once, 2: random
    int obsLog[$];
    int obsCyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mBusy = 0; mPtr = 0; mCur = 0; mTimer = 0;
        eOut = '0; eGnt = '0; eReqDn = 0; eFull = 0;
        ePkt = 0; eDrop = 0; eLast = 0;
    endtask

    // Advance the model by one clock edge using the inputs present before it.
    task automatic modelStep();
        logic [N-1:0] elig;
        int w;
        bit found, grant;
        elig = ReqUpStr;
        if (mBusy) elig[mCur] = 1'b0;
        found = 0; w = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && elig[(mPtr + k) % N]) begin
                found = 1;
                w = (mPtr + k) % N;
            end
        end
        eGnt = '0;
        grant = 0;
        if (!mBusy) begin
            if (found) begin grant = 1; eReqDn = !DnStrFull; end
        end else if (GntDnStr) begin
            ePkt = (ePkt + 1) % (1 << CW);
            if (found) begin
                grant = 1; eReqDn = 1;
            end else begin
                mBusy = 0; eReqDn = 0; eFull = 0;
            end
        end else begin
            mTimer++;
            if (mTimer == TO) begin
                eDrop = (eDrop + 1) % (1 << CW);
                mBusy = 0; eReqDn = 0; eFull = 0;
            end else begin
                eReqDn = !DnStrFull;
            end
        end
        if (grant) begin
            eOut = PacketIn[w*DW +: DW];
            eGnt[w] = 1'b1;
            eLast = w; mCur = w; mPtr = (w + 1) % N;
            mTimer = 0; mBusy = 1; eFull = 1;
        end
    endtask

    task automatic checkAll(input string ph);
        chk({ph, ".gnt"},  GntUpStr,   eGnt);
        chk({ph, ".full"}, UpStrFull,  {N{eFull}});
        chk({ph, ".pout"}, PacketOut,  eOut);
        chk({ph, ".reqdn"}, ReqDnStr,  eReqDn);
        chk({ph, ".pkts"}, PktCount,   ePkt);
        chk({ph, ".drops"}, DropCount, eDrop);
        chk({ph, ".last"}, LastSender, eLast);
    endtask

    // Collector (registered, one-cycle grant per sampled request) and ports.
    task automatic envStep(input bit reqDnBefore);
        GntDnStr = collOn && reqDnBefore && !GntDnStr;
        for (int i = 0; i < N; i++) begin
            if (eGnt[i]) begin
                ReqUpStr[i] = 1'b0;
            end else if (!ReqUpStr[i] &&
                         (pmode[i] == 1 || (pmode[i] == 2 && $urandom_range(0, 3) == 0))) begin
                ReqUpStr[i] = 1'b1;
                PacketIn[i*DW +: DW] = $urandom;
            end
        end
    endtask

    task automatic cycle();
        bit rb;
        @(posedge clk);
        rb = eReqDn;
        modelStep();
        @(negedge clk);
        cyc++;
        checkAll(phase);
        for (int i = 0; i < N; i++) begin
            if (GntUpStr[i]) begin
                obsLog.push_back(i);
                obsCyc.push_back(cyc);
            end
        end
        envStep(rb);
    endtask

    initial begin
        int n;
        reset = 1'b0; PacketIn = '0; ReqUpStr = '0; GntDnStr = 1'b0; DnStrFull = 1'b0;
        collOn = 1;
        for (int i = 0; i < N; i++) pmode[i] = 0;
        modelReset();
        #12;
        checkAll("reset");
        @(negedge clk);
        reset = 1'b1;

        // Fairness: all ports stream requests.
        phase = "fair";
        for (int i = 0; i < N; i++) begin
            pmode[i] = 1;
            ReqUpStr[i] = 1'b1;
            PacketIn[i*DW +: DW] = $urandom;
        end
        obsLog.delete(); obsCyc.delete();
        repeat (12) cycle();
        chk("fair.ngrants", obsLog.size(), 6);
        for (int i = 0; i < obsLog.size() && i < 6; i++) begin
            chk($sformatf("fair.order%0d", i), obsLog[i], i % N);
            if (i > 0) chk($sformatf("fair.period%0d", i), obsCyc[i] - obsCyc[i-1], 2);
        end
        for (int i = 0; i < N; i++) pmode[i] = 0;
        repeat (16) cycle();
        chk("fair.total", PktCount, 10);

        // Single request from port 2.
        phase = "single";
        PacketIn[2*DW +: DW] = 32'h0000_A5C3;
        ReqUpStr[2] = 1'b1;
        cycle();
        chk("single.gnt", GntUpStr, 4'b0100);
        chk("single.pout", PacketOut, 32'h0000_A5C3);
        chk("single.full", UpStrFull, 4'b1111);
        cycle();
        chk("single.gntlow", GntUpStr, 4'b0000);
        cycle();
        chk("single.pkts", PktCount, 11);
        chk("single.last", LastSender, 2);
        chk("single.idle", UpStrFull, 4'b0000);
        chk("single.reqdn", ReqDnStr, 1'b0);

        // Pointer wrap: pointer is 3, ports 3 and 0 request.
        phase = "wrap";
        obsLog.delete(); obsCyc.delete();
        ReqUpStr[3] = 1'b1; PacketIn[3*DW +: DW] = $urandom;
        ReqUpStr[0] = 1'b1; PacketIn[0*DW +: DW] = $urandom;
        repeat (6) cycle();
        chk("wrap.ngrants", obsLog.size(), 2);
        if (obsLog.size() >= 2) begin
            chk("wrap.first", obsLog[0], 3);
            chk("wrap.second", obsLog[1], 0);
        end
        chk("wrap.pkts", PktCount, 13);

        // Timeout: collector never grants.
        phase = "timeout";
        collOn = 0;
        ReqUpStr[1] = 1'b1; PacketIn[1*DW +: DW] = $urandom;
        n = 0;
        repeat (8) begin
            cycle();
            if (ReqDnStr === 1'b1) n++;
        end
        chk("timeout.reqdn_cycles", n, 5);
        chk("timeout.drops", DropCount, 1);
        chk("timeout.pkts", PktCount, 13);
        chk("timeout.full", UpStrFull, 4'b0000);

        // Back-pressure for 3 cycles, then a grant colliding with expiry.
        phase = "bp";
        collOn = 1;
        DnStrFull = 1'b1;
        ReqUpStr[2] = 1'b1; PacketIn[2*DW +: DW] = $urandom;
        repeat (3) begin
            cycle();
            chk("bp.held_low", ReqDnStr, 1'b0);
        end
        DnStrFull = 1'b0;
        cycle();
        chk("bp.release", ReqDnStr, 1'b1);
        cycle();
        cycle();
        chk("collide.pkts", PktCount, 14);
        chk("collide.drops", DropCount, 1);
        chk("collide.full", UpStrFull, 4'b0000);

        // Random traffic.
        phase = "rand";
        for (int i = 0; i < N; i++) pmode[i] = 2;
        repeat (400) begin
            if ($urandom_range(0, 9) == 0) collOn = !collOn;
            DnStrFull = ($urandom_range(0, 7) == 0);
            cycle();
        end
        for (int i = 0; i < N; i++) pmode[i] = 0;
        collOn = 1; DnStrFull = 1'b0;
        repeat (40) cycle();

        // Reset mid-transfer, starting from cleared counters.
        phase = "rstmid";
        reset = 1'b0; ReqUpStr = '0; GntDnStr = 1'b0;
        modelReset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        collOn = 0;
        ReqUpStr = 4'b0010; PacketIn[1*DW +: DW] = $urandom;
        cycle();
        chk("rstmid.busy", UpStrFull, 4'b1111);
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkAll("rstmid.async");
        chk("rstmid.pkts", PktCount, 0);
        chk("rstmid.drops", DropCount, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        GntDnStr = 1'b0;
        ReqUpStr = 4'b1010;
        PacketIn[1*DW +: DW] = $urandom;
        PacketIn[3*DW +: DW] = $urandom;
        cycle();
        chk("rstmid.regrant", GntUpStr, 4'b0010);
        chk("rstmid.last", LastSender, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
